// File: rtl/rob_scheduler_if.sv
// Issue, dispatch, completion and commit signals of the reorder buffer.
// The slave modport is the buffer itself; master is the surrounding pipeline.
interface rob_scheduler_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  localparam int ID_W = $clog2(DEPTH);

  logic            issue_valid;
  logic            issue_ready;
  logic            issue_type;
  logic [31:0]     issue_ins;
  logic [XLEN-1:0] issue_pc;
  logic [4:0]      issue_rd;

  logic            alu_valid;
  logic            alu_ready;
  logic [ID_W-1:0] alu_id;
  logic [31:0]     alu_ins;
  logic [XLEN-1:0] alu_pc;

  logic            mem_valid;
  logic            mem_ready;
  logic [ID_W-1:0] mem_id;
  logic [31:0]     mem_ins;
  logic [XLEN-1:0] mem_pc;

  logic            cmp_valid;
  logic [ID_W-1:0] cmp_id;
  logic [XLEN-1:0] cmp_value;
  logic            cmp_mispredict;
  logic [XLEN-1:0] cmp_target;

  logic            commit_valid;
  logic [4:0]      commit_rd;
  logic [XLEN-1:0] commit_value;

  logic            flush_pipeline;
  logic [XLEN-1:0] flush_pc;
  logic [ID_W:0]   count;

  modport master (
    output issue_valid, issue_type, issue_ins, issue_pc, issue_rd,
    input  issue_ready,
    input  alu_valid, alu_id, alu_ins, alu_pc,
    output alu_ready,
    input  mem_valid, mem_id, mem_ins, mem_pc,
    output mem_ready,
    output cmp_valid, cmp_id, cmp_value, cmp_mispredict, cmp_target,
    input  commit_valid, commit_rd, commit_value,
    input  flush_pipeline, flush_pc, count
  );

  modport slave (
    input  issue_valid, issue_type, issue_ins, issue_pc, issue_rd,
    output issue_ready,
    output alu_valid, alu_id, alu_ins, alu_pc,
    input  alu_ready,
    output mem_valid, mem_id, mem_ins, mem_pc,
    input  mem_ready,
    input  cmp_valid, cmp_id, cmp_value, cmp_mispredict, cmp_target,
    output commit_valid, commit_rd, commit_value,
    output flush_pipeline, flush_pc, count
  );
endinterface

// File: rtl/rob_scheduler.sv
// Reorder buffer: in-order issue and commit, independent ALU/MEM dispatch,
// out-of-order completion, full flush on a committed mispredict.
//   state     | meaning
//   EMPTY     | slot free
//   WAITING   | issued, awaiting dispatch on its channel
//   EXECUTING | dispatched, awaiting completion
//   DONE      | result captured, awaiting in-order commit
module rob_scheduler #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic            clk_in,
  input logic            rst_in,
  input logic            rdy_in,
  rob_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, WAITING, EXECUTING, DONE} ent_state_e;

  typedef struct packed {
    ent_state_e      state;
    logic            typ;
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
    logic            mispredict;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t          ent     [DEPTH];
  entry_t          ent_nxt [DEPTH];
  logic [ID_W:0]   head, tail, head_nxt, tail_nxt;
  logic [ID_W-1:0] head_idx, tail_idx;
  logic            full;

  logic            commit_valid_q, commit_valid_nxt;
  logic            flush_q, flush_nxt;
  logic [4:0]      commit_rd_q, commit_rd_nxt;
  logic [XLEN-1:0] commit_value_q, commit_value_nxt;
  logic [XLEN-1:0] flush_pc_q, flush_pc_nxt;

  logic            alu_found, mem_found;
  logic [ID_W-1:0] alu_idx, mem_idx, scan_idx;
  logic            issue_fire, alu_fire, mem_fire;

  assign head_idx = head[ID_W-1:0];
  assign tail_idx = tail[ID_W-1:0];
  assign full     = (head[ID_W] != tail[ID_W]) && (head_idx == tail_idx);

  assign bus.issue_ready = ~full & rdy_in;
  assign bus.count       = tail - head;

  // Scan youngest-to-oldest so the last hit is the one closest to head.
  always_comb begin
    alu_found = 1'b0;
    mem_found = 1'b0;
    alu_idx   = '0;
    mem_idx   = '0;
    scan_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      scan_idx = head_idx + ID_W'(i);
      if (ent[scan_idx].state == WAITING) begin
        if (ent[scan_idx].typ) begin
          mem_found = 1'b1;
          mem_idx   = scan_idx;
        end else begin
          alu_found = 1'b1;
          alu_idx   = scan_idx;
        end
      end
    end
  end

  assign bus.alu_valid = alu_found & rdy_in;
  assign bus.alu_id    = alu_idx;
  assign bus.alu_ins   = ent[alu_idx].ins;
  assign bus.alu_pc    = ent[alu_idx].pc;

  assign bus.mem_valid = mem_found & rdy_in;
  assign bus.mem_id    = mem_idx;
  assign bus.mem_ins   = ent[mem_idx].ins;
  assign bus.mem_pc    = ent[mem_idx].pc;

  assign issue_fire = bus.issue_valid & bus.issue_ready;
  assign alu_fire   = bus.alu_valid & bus.alu_ready;
  assign mem_fire   = bus.mem_valid & bus.mem_ready;

  always_comb begin
    ent_nxt          = ent;
    head_nxt         = head;
    tail_nxt         = tail;
    commit_valid_nxt = 1'b0;
    flush_nxt        = 1'b0;
    commit_rd_nxt    = commit_rd_q;
    commit_value_nxt = commit_value_q;
    flush_pc_nxt     = flush_pc_q;
    if (rdy_in) begin
      if (issue_fire) begin
        ent_nxt[tail_idx].state      = WAITING;
        ent_nxt[tail_idx].typ        = bus.issue_type;
        ent_nxt[tail_idx].ins        = bus.issue_ins;
        ent_nxt[tail_idx].pc         = bus.issue_pc;
        ent_nxt[tail_idx].rd         = bus.issue_rd;
        ent_nxt[tail_idx].value      = '0;
        ent_nxt[tail_idx].mispredict = 1'b0;
        ent_nxt[tail_idx].target     = '0;
        tail_nxt                     = tail + 1'b1;
      end
      if (alu_fire) ent_nxt[alu_idx].state = EXECUTING;
      if (mem_fire) ent_nxt[mem_idx].state = EXECUTING;
      if (bus.cmp_valid && ent[bus.cmp_id].state == EXECUTING) begin
        ent_nxt[bus.cmp_id].state      = DONE;
        ent_nxt[bus.cmp_id].value      = bus.cmp_value;
        ent_nxt[bus.cmp_id].mispredict = bus.cmp_mispredict;
        ent_nxt[bus.cmp_id].target     = bus.cmp_target;
      end
      if (ent[head_idx].state == DONE) begin
        commit_valid_nxt       = 1'b1;
        commit_rd_nxt          = ent[head_idx].rd;
        commit_value_nxt       = ent[head_idx].value;
        ent_nxt[head_idx].state = EMPTY;
        head_nxt               = head + 1'b1;
        // A mispredict wipes everything younger, including this edge's issue/dispatch/completion.
        if (ent[head_idx].mispredict) begin
          flush_nxt    = 1'b1;
          flush_pc_nxt = ent[head_idx].target;
          for (int i = 0; i < DEPTH; i++) ent_nxt[i] = '0;
          head_nxt = '0;
          tail_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head           <= '0;
      tail           <= '0;
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      flush_pc_q     <= '0;
    end else begin
      ent            <= ent_nxt;
      head           <= head_nxt;
      tail           <= tail_nxt;
      commit_valid_q <= commit_valid_nxt;
      flush_q        <= flush_nxt;
      commit_rd_q    <= commit_rd_nxt;
      commit_value_q <= commit_value_nxt;
      flush_pc_q     <= flush_pc_nxt;
    end
  end

  assign bus.commit_valid   = commit_valid_q;
  assign bus.commit_rd      = commit_rd_q;
  assign bus.commit_value   = commit_value_q;
  assign bus.flush_pipeline = flush_q;
  assign bus.flush_pc       = flush_pc_q;
endmodule
